mem_stream_reader: RTL

Upstream feeder for the Sobel pipeline. On a start pulse from the system controller, it reads one full image, `IMG_W*IMG_H` bytes, out of a synchronous-read image memory in raster order. It presents the bytes as the 8-bit `data_o`/`data_en_o` stream that drives the Sobel top's `DATA_I`/`DATA_EN_I`. There is no backpressure: the Sobel preprocess stage must accept every byte on the cycle it is presented.

---
 rtl/mem_stream_reader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_stream_reader.sv
// Reads one IMG_W*IMG_H frame from a sync-read memory and streams it as bytes; read-to-byte latency 2 cycles, no backpressure.
// Optional macro MEM_STREAM_PACE_EN spaces reads PACE cycles apart; without it reads are back-to-back.
module mem_stream_reader #(
  parameter int IMG_W     = 64,
  parameter int IMG_H     = 64,
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0,
  parameter int PACE      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_data_i,
  output logic [7:0]        data_o,
  output logic              data_en_o
);

  localparam int N     = IMG_W * IMG_H;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0]  LAST = CNT_W'(N - 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t              state_q;
  logic                busy_q, done_q, mem_rd_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]    pix_cnt_q, pix_cnt_d;
  logic                rd_d1_q;
  logic [7:0]          data_q;
  logic                data_en_q;
  logic                issue_nxt;

  assign addr_d    = addr_q + ADDR_W'(1);
  assign rd_cnt_d  = rd_cnt_q + CNT_W'(1);
  assign pix_cnt_d = pix_cnt_q + CNT_W'(1);

`ifdef MEM_STREAM_PACE_EN
  localparam logic [3:0] PACE_M1 = 4'(PACE - 1);
  logic [3:0] pace_q;

  // pace_q counts cycles since the last issue; it is zero in the first READ cycle
  assign issue_nxt = (pace_q == PACE_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pace_q <= '0;
    end else if (state_q != READ || issue_nxt) begin
      pace_q <= '0;
    end else begin
      pace_q <= pace_q + 4'd1;
    end
  end
`else
  assign issue_nxt = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mem_rd_q  <= 1'b0;
      addr_q    <= '0;
      rd_cnt_q  <= '0;
      pix_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          rd_cnt_q  <= '0;
          pix_cnt_q <= '0;
          if (start_i) begin
            state_q  <= READ;
            busy_q   <= 1'b1;
            mem_rd_q <= 1'b1;
            addr_q   <= BASE;
          end
        end
        READ: begin
          if (data_en_q) pix_cnt_q <= pix_cnt_d;
          if (mem_rd_q && rd_cnt_q == LAST) begin
            state_q  <= DRAIN;
            mem_rd_q <= 1'b0;
          end else begin
            mem_rd_q <= issue_nxt;
            if (issue_nxt) begin
              addr_q   <= addr_d;
              rd_cnt_q <= rd_cnt_d;
            end
          end
        end
        DRAIN: begin
          if (data_en_q) begin
            pix_cnt_q <= pix_cnt_d;
            if (pix_cnt_q == LAST) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          mem_rd_q <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage read path: rd_d1_q marks the cycle mem_data_i is valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_d1_q   <= 1'b0;
      data_q    <= '0;
      data_en_q <= 1'b0;
    end else begin
      rd_d1_q   <= mem_rd_q;
      data_en_q <= rd_d1_q;
      if (rd_d1_q) data_q <= mem_data_i;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign mem_rd_o   = mem_rd_q;
  assign mem_addr_o = addr_q;
  assign data_o     = data_q;
  assign data_en_o  = data_en_q;

endmodule
